// File: rtl/matmul_pkg.sv
// Shared matmul types and sizes: element/bus widths,
// max matrix dimension and the operand-feeder FSM states.
package matmul_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BUS_WIDTH  = 64;
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FEED = 2'd2,
    ST_DONE = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/feeder_lane.sv
// One systolic lane: picks the element for lane LANE at feed step t_i.
// In: act_i, t_i, n_i, rows_i. Out: data_o, valid_o (combinational).
// OPERAND_FEEDER_TRANSPOSE_EN selects column (B operand) mapping.
module feeder_lane #(
  parameter int DW        = 32,
  parameter int BUS_WIDTH = 64,
  parameter int MAX_DIM   = 2,
  parameter int NW        = 2,
  parameter int CW        = 3,
  parameter int LANE      = 0
) (
  input  logic                                act_i,
  input  logic [CW-1:0]                       t_i,
  input  logic [NW-1:0]                       n_i,
  input  logic [MAX_DIM-1:0][BUS_WIDTH-1:0]   rows_i,
  output logic [DW-1:0]                       data_o,
  output logic                                valid_o
);
  import matmul_pkg::*;

  logic [CW-1:0] idx;
  logic          in_win;

  always_comb begin
    idx    = t_i - CW'(LANE);
    in_win = act_i
           && (NW'(LANE) < n_i)
           && (t_i >= CW'(LANE))
           && (idx < {1'b0, n_i});
    data_o = '0;
`ifdef OPERAND_FEEDER_TRANSPOSE_EN
    for (int k = 0; k < MAX_DIM; k++) begin
      if (in_win && CW'(k) == idx) begin
        data_o = rows_i[k][LANE*DW +: DW];
      end
    end
`else
    for (int k = 0; k < MAX_DIM; k++) begin
      if (in_win && CW'(k) == idx) begin
        data_o = rows_i[LANE][k*DW +: DW];
      end
    end
`endif
    valid_o = in_win;
  end

endmodule

// File: rtl/operand_feeder.sv
// Loads N operand rows from the store, then feeds them diagonally
// skewed into MAX_DIM lanes. Ports: clk_i, rst_ni, start_i, n_dim_i,
// start_send_o, op_data_i, feed_o, feed_valid_o, busy_o, done_o.
// Option: OPERAND_FEEDER_TRANSPOSE_EN feeds columns instead of rows.
module operand_feeder #(
  parameter int  DATA_WIDTH = matmul_pkg::DATA_WIDTH,
  parameter int  BUS_WIDTH  = matmul_pkg::BUS_WIDTH,
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int NW         = $clog2(MAX_DIM) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [NW-1:0]               n_dim_i,
  output logic                        start_send_o,
  input  logic [BUS_WIDTH-1:0]        op_data_i,
  output logic [MAX_DIM*DATA_WIDTH-1:0] feed_o,
  output logic [MAX_DIM-1:0]          feed_valid_o,
  output logic                        busy_o,
  output logic                        done_o
);
  import matmul_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int CW = NW + 1;

  feeder_state_e state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MAX_DIM-1:0][BUS_WIDTH-1:0] rows_q, rows_d;
  logic [MAX_DIM*DW-1:0] feed_q, feed_d;
  logic [MAX_DIM-1:0] fv_q, fv_d;

  logic          act_d;
  logic [CW-1:0] t_d;
  logic [NW-1:0] n_clamp;
  logic [CW-1:0] n_m1;
  logic [CW-1:0] last_t;

  always_comb begin
    n_clamp = n_dim_i;
    if (n_dim_i == '0 || n_dim_i > NW'(MAX_DIM)) begin
      n_clamp = NW'(MAX_DIM);
    end
    n_m1   = {1'b0, n_q} - CW'(1);
    last_t = {n_q, 1'b0} - CW'(2);
  end

  // Lane outputs are computed from the next-cycle view (rows_d, t_d)
  // so the registered feed lines up with the FEED step it belongs to,
  // including the row captured on the same edge that enters FEED.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    rows_d  = rows_q;
    act_d   = 1'b0;
    t_d     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          n_d     = n_clamp;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        for (int k = 0; k < MAX_DIM; k++) begin
          if (CW'(k) == cnt_q) begin
            rows_d[k] = op_data_i;
          end
        end
        if (cnt_q == n_m1) begin
          state_d = ST_FEED;
          cnt_d   = '0;
          act_d   = 1'b1;
          t_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FEED: begin
        if (cnt_q == last_t) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          act_d = 1'b1;
          t_d   = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  for (genvar g = 0; g < MAX_DIM; g++) begin : g_lane
    feeder_lane #(
      .DW       (DW),
      .BUS_WIDTH(BUS_WIDTH),
      .MAX_DIM  (MAX_DIM),
      .NW       (NW),
      .CW       (CW),
      .LANE     (g)
    ) u_lane (
      .act_i  (act_d),
      .t_i    (t_d),
      .n_i    (n_q),
      .rows_i (rows_d),
      .data_o (feed_d[g*DW +: DW]),
      .valid_o(fv_d[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      rows_q  <= '0;
      feed_q  <= '0;
      fv_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      rows_q  <= rows_d;
      feed_q  <= feed_d;
      fv_q    <= fv_d;
    end
  end

  assign start_send_o = (state_q == ST_LOAD);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign feed_o       = feed_q;
  assign feed_valid_o = fv_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Bench for operand_feeder: directed plus random operations checked
// against a formula-level model of the diagonal feed.
module tb_operand_feeder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [1:0]  n_dim_i;
  logic        start_send_o;
  logic [63:0] op_data_i;
  logic [63:0] feed_o;
  logic [1:0]  feed_valid_o;
  logic        busy_o;
  logic        done_o;

  int total = 0;
  int bad   = 0;

  operand_feeder dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .n_dim_i     (n_dim_i),
    .start_send_o(start_send_o),
    .op_data_i   (op_data_i),
    .feed_o      (feed_o),
    .feed_valid_o(feed_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Expected lanes at FEED step t: lane r shows A[r][t-r]
  // (or A[t-r][r] for the transposed build) inside the window.
  task automatic model(input logic [1:0][63:0] rows, input int n,
                       input int t, output logic [63:0] data,
                       output logic [1:0] valid);
    data  = '0;
    valid = '0;
    for (int r = 0; r < 2; r++) begin
      int d;
      d = t - r;
      if (r < n && d >= 0 && d < n) begin
        valid[r] = 1'b1;
`ifdef OPERAND_FEEDER_TRANSPOSE_EN
        data[r*32 +: 32] = rows[d][r*32 +: 32];
`else
        data[r*32 +: 32] = rows[r][d*32 +: 32];
`endif
      end
    end
  endtask

  // Called at 1ns after a posedge with the DUT idle.
  task automatic run(input int nin, input logic [1:0][63:0] rows,
                     input bit inj, input bit abort, input bit dstart);
    int n;
    logic [63:0] ed;
    logic [1:0]  ev;
    n = (nin == 0 || nin > 2) ? 2 : nin;
    start_i = 1'b1;
    n_dim_i = 2'(nin);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n_dim_i = 2'($urandom_range(0, 3));
    chk("load_send", 64'(start_send_o), 64'd1);
    chk("load_busy", 64'(busy_o), 64'd1);
    for (int k = 0; k < n; k++) begin
      op_data_i = rows[k];
      @(posedge clk_i); #1;
      op_data_i = {$urandom, $urandom};
      chk("send", 64'(start_send_o), 64'(k < n - 1));
    end
    for (int t = 0; t < 2 * n - 1; t++) begin
      model(rows, n, t, ed, ev);
      chk("feed_data", feed_o, ed);
      chk("feed_valid", 64'(feed_valid_o), 64'(ev));
      chk("feed_done", 64'(done_o), 64'd0);
      if (abort && t == 1) begin
        rst_ni = 1'b0;
        #1;
        chk("rst_feed", feed_o, 64'd0);
        chk("rst_valid", 64'(feed_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_send", 64'(start_send_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
          @(posedge clk_i); #1;
          chk("abort_done", 64'(done_o), 64'd0);
          chk("abort_busy", 64'(busy_o), 64'd0);
        end
        return;
      end
      if (inj && t == 0) begin
        start_i = 1'b1;
        n_dim_i = 2'd1;
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    chk("done", 64'(done_o), 64'd1);
    chk("done_valid", 64'(feed_valid_o), 64'd0);
    chk("done_feed", feed_o, 64'd0);
    chk("done_busy", 64'(busy_o), 64'd1);
    if (dstart) start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("idle_done", 64'(done_o), 64'd0);
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("idle_send", 64'(start_send_o), 64'd0);
  endtask

  initial begin
    logic [1:0][63:0] fix;
    logic [1:0][63:0] rnd;
    fix[0] = 64'h00000002_00000001;
    fix[1] = 64'h00000004_00000003;
    rst_ni    = 1'b0;
    start_i   = 1'b0;
    n_dim_i   = '0;
    op_data_i = '0;
    #1;
    chk("rst_busy0", 64'(busy_o), 64'd0);
    chk("rst_feed0", feed_o, 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("idle_busy0", 64'(busy_o), 64'd0);
    chk("idle_done0", 64'(done_o), 64'd0);
    chk("idle_send0", 64'(start_send_o), 64'd0);
    chk("idle_valid0", 64'(feed_valid_o), 64'd0);

    run(2, fix, 1'b0, 1'b0, 1'b0);
    run(1, fix, 1'b0, 1'b0, 1'b0);
    run(2, fix, 1'b1, 1'b0, 1'b0);
    run(2, fix, 1'b0, 1'b1, 1'b0);
    run(2, fix, 1'b0, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    chk("dstart_ignored", 64'(busy_o), 64'd0);
    run(0, fix, 1'b0, 1'b0, 1'b0);
    run(3, fix, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rnd[0] = {$urandom, $urandom};
      rnd[1] = {$urandom, $urandom};
      run($urandom_range(0, 3), rnd, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
- REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of one matrix element.
- REQ-002 The block SHALL have parameter BUS_WIDTH, default 64, meaning the width of one operand row.
- REQ-003 The block SHALL derive localparam MAX_DIM = BUS_WIDTH/DATA_WIDTH, meaning the maximum matrix dimension; DW denotes DATA_WIDTH below.
- REQ-004 The block SHALL have port clk_i, input, 1 bit: clock.
- REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 The block SHALL have port start_i, input, 1 bit: single-cycle request to load and feed one operand matrix.
- REQ-007 The block SHALL have port n_dim_i, input, $clog2(MAX_DIM)+1 bits: active dimension, sampled with start_i.
- REQ-008 The block SHALL have port start_send_o, output, 1 bit: drives the operand store's start_send_i.
- REQ-009 The block SHALL have port op_data_i, input, BUS_WIDTH bits: row data returned by the operand store.
- REQ-010 The block SHALL have port feed_o, output, MAX_DIM*DW bits: one element per lane; lane r is bits [(r+1)*DW-1 -: DW].
- REQ-011 The block SHALL have port feed_valid_o, output, MAX_DIM bits: per-lane valid.
- REQ-012 The block SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.
- REQ-013 The block SHALL have port done_o, output, 1 bit: single-cycle completion pulse.

Function
- REQ-014 The FSM SHALL have the states IDLE, LOAD, FEED and DONE, with the transitions IDLE->LOAD, LOAD->FEED, FEED->DONE and DONE->IDLE.
- REQ-015 In IDLE, start_i high at edge E SHALL latch N (the clamped n_dim_i), enter LOAD, and register start_send_o=1 from edge E.
- REQ-016 N SHALL be clamped: n_dim_i of 0, or greater than MAX_DIM, SHALL be treated as MAX_DIM.
- REQ-017 In LOAD, op_data_i SHALL be captured into row buffer k at edge E+1+k, for k=0..N-1, because the operand store presents row k combinationally while start_send is high.
- REQ-018 start_send_o SHALL deassert at the edge that captures row N-1, and the FSM SHALL enter FEED at that same edge.
- REQ-019 FEED SHALL last exactly 2N-1 cycles, t=0..2N-2.
- REQ-020 In FEED cycle t, lane r SHALL output element (t-r) of row r with valid=1 when 0<=t-r<N and r<N; otherwise the lane SHALL output 0 with valid=0 (diagonal skew).
- REQ-021 Element k of a row SHALL be bits [(k+1)*DW-1 -: DW] of that row.
- REQ-022 feed_o and feed_valid_o SHALL be registered outputs with no combinational path from any input.
- REQ-023 After the last FEED cycle, done_o SHALL be 1 for exactly one cycle (state DONE), after which the FSM SHALL return to IDLE.
- REQ-024 start_i asserted while busy_o=1 SHALL be ignored, with no effect on the sampled N, the row buffers or the FSM.
- REQ-025 start_i asserted in the DONE cycle SHALL be ignored; start_i asserted in the first IDLE cycle SHALL be accepted.
- REQ-026 Changes on n_dim_i SHALL have no effect after it has been sampled with start_i.
- REQ-027 Lane counters SHALL not wrap; no lane SHALL output a valid element outside the window defined in REQ-020.

Reset
- REQ-028 Assertion of rst_ni SHALL immediately force IDLE, start_send_o=0, feed_o=0, feed_valid_o=0, busy_o=0, done_o=0, all row buffers to 0 and all counters to 0.
- REQ-029 Reset asserted mid-LOAD or mid-FEED SHALL abort the operation, with no done_o pulse afterwards.

Configuration
- REQ-030 With macro OPERAND_FEEDER_TRANSPOSE_EN defined, lane r in cycle t SHALL output element r of row (t-r), i.e. the columns fed for the B operand, with the same valid window.
- REQ-031 With OPERAND_FEEDER_TRANSPOSE_EN undefined, the row mapping of REQ-020 SHALL apply and no transpose logic SHALL be present.

Structure
- REQ-032 DATA_WIDTH, BUS_WIDTH, MAX_DIM and the FSM state enum SHALL live in the shared package matmul_pkg.
- REQ-033 Per-lane skew/select logic SHALL be one sub-module, feeder_lane, instantiated MAX_DIM times by a generate loop.

Verification (MAX_DIM=2; row0=64'h00000002_00000001, row1=64'h00000004_00000003)
- REQ-034 Reset then idle -> all outputs 0, busy_o=0.
- REQ-035 start_i with n_dim_i=2 -> start_send_o high for 2 cycles; FEED: t0 feed_valid_o=01 lane0=1; t1 11 lane0=2 lane1=3; t2 10 lane1=4; done_o pulses next cycle.
- REQ-036 start_i with n_dim_i=1 -> 1 capture cycle, 1 FEED cycle (lane0=1, valid=01), then done_o.
- REQ-037 start_i pulsed during FEED with n_dim_i=1 -> ignored; original N=2 sequence completes unchanged.
- REQ-038 rst_ni low during FEED t1 -> outputs 0 in the same cycle, no done_o, and a subsequent start_i works normally.
- REQ-039 OPERAND_FEEDER_TRANSPOSE_EN defined, n_dim_i=2 -> lane0 outputs 1 then 3; lane1 outputs 2 then 4, skewed one cycle.
